// File: rtl/gearbox_22_20_if.sv
// Stream bundle for the 22->20 transmit gearbox: 22-bit words in, 20-bit words out.
// The master drives din/din_valid, and the slave (the gearbox) drives the rest.
interface gearbox_22_20_if;
    logic [21:0] din;
    logic        din_valid;
    logic        din_ready;
    logic [19:0] dout;
    logic        dout_valid;

    modport master (
        output din, din_valid,
        input  din_ready, dout, dout_valid
    );

    modport slave (
        input  din, din_valid,
        output din_ready, dout, dout_valid
    );
endinterface

// File: rtl/gearbox_22_20.sv
// Transmit gearbox: packs 22-bit words into a 42-bit bit buffer, lsbit first, and emits 20-bit words.
// Optional macro GB_SLIP_EN adds a slip input that drops the oldest buffered bit, for link alignment.
module gearbox_22_20 (
    input  logic            clk,
    input  logic            arst_n,
`ifdef GB_SLIP_EN
    input  logic            slip,
`endif
    gearbox_22_20_if.slave  bus
);
    localparam int IN_W  = 22;
    localparam int OUT_W = 20;
    localparam int BUF_W = 42;

    logic [BUF_W-1:0] storage;
    logic [BUF_W-1:0] storage_s;
    logic [BUF_W-1:0] din_ext;
    logic [BUF_W-1:0] keep_mask;
    logic [BUF_W-1:0] buf_a;
    logic [5:0]       count;
    logic [5:0]       count_s;
    logic [5:0]       c1;
    logic [OUT_W-1:0] dout_q;
    logic             dout_valid_q;
    logic             accept;
    logic             emit;

    // Ready looks only at the registered count, so it is never combinational from din_valid or slip.
    assign bus.din_ready  = (count < 6'd20);
    assign accept         = bus.din_valid & bus.din_ready;
    assign bus.dout       = dout_q;
    assign bus.dout_valid = dout_valid_q;

`ifdef GB_SLIP_EN
    logic do_slip;
    assign do_slip   = slip & (count != 6'd0);
    assign storage_s = do_slip ? (storage >> 1) : storage;
    assign count_s   = count - {5'd0, do_slip};
`else
    assign storage_s = storage;
    assign count_s   = count;
`endif

    // Bits at and above count_s are stale and are masked off before the new word is merged in.
    assign din_ext   = {{(BUF_W-IN_W){1'b0}}, bus.din};
    assign keep_mask = ~({BUF_W{1'b1}} << count_s);
    assign buf_a     = accept ? ((storage_s & keep_mask) | (din_ext << count_s)) : storage_s;
    assign c1        = count_s + (accept ? 6'd22 : 6'd0);
    assign emit      = (c1 >= 6'd20);

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            storage      <= '0;
            count        <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
        end else if (emit) begin
            dout_q       <= buf_a[OUT_W-1:0];
            storage      <= buf_a >> OUT_W;
            count        <= c1 - 6'd20;
            dout_valid_q <= 1'b1;
        end else begin
            storage      <= buf_a;
            count        <= c1;
            dout_valid_q <= 1'b0;
        end
    end
endmodule

// File: tb/tb_gearbox_22_20.sv
// Bench for gearbox_22_20: directed vector table plus a bit-queue scoreboard for streaming cases.
module tb_gearbox_22_20;
    logic clk;
    logic arst_n;
    logic slip;

    gearbox_22_20_if bus();

    gearbox_22_20 dut (
        .clk    (clk),
        .arst_n (arst_n),
`ifdef GB_SLIP_EN
        .slip   (slip),
`endif
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_err    = 0;
    bit          q[$];
    logic [19:0] last_dout;

    typedef struct {
        logic        v;
        logic [21:0] d;
        logic        rdy;
        logic        dv;
        logic [19:0] dout;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        arst_n        = 1'b0;
        bus.din_valid = 1'b0;
        bus.din       = '0;
        slip          = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        arst_n    = 1'b1;
        q.delete();
        last_dout = '0;
    endtask

    // One clock against the scoreboard; entered and left at posedge+1.
    task automatic run_cycle(input logic v, input logic [21:0] d, input logic s, output logic acc);
        logic        rdy_exp;
        logic        dv_exp;
        logic [19:0] w;
        bus.din_valid = v;
        bus.din       = d;
        slip          = s;
        #1;
        rdy_exp = (q.size() < 20);
        chk("din_ready", {31'd0, bus.din_ready}, {31'd0, rdy_exp});
        acc = v && rdy_exp;
        @(posedge clk);
        #1;
        if (s && q.size() > 0) begin
`ifdef GB_SLIP_EN
            void'(q.pop_front());
`endif
        end
        if (acc) for (int i = 0; i < 22; i++) q.push_back(d[i]);
        if (q.size() >= 20) begin
            dv_exp = 1'b1;
            w      = '0;
            for (int i = 0; i < 20; i++) w[i] = q.pop_front();
            last_dout = w;
        end else begin
            dv_exp = 1'b0;
        end
        chk("dout_valid", {31'd0, bus.dout_valid}, {31'd0, dv_exp});
        chk("dout_bits", {12'd0, bus.dout}, {12'd0, last_dout});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t        tbl[7];
        logic        acc;
        logic        rdy_s;
        logic        pending;
        logic        v;
        logic [21:0] word;

        // After reset: 3FFFFF emits FFFFF leaving 2 ones; 0 then yields 00003, and so on.
        tbl[0] = '{1'b1, 22'h3FFFFF, 1'b1, 1'b1, 20'hFFFFF};
        tbl[1] = '{1'b0, 22'h000000, 1'b1, 1'b0, 20'hFFFFF};
        tbl[2] = '{1'b0, 22'h123456, 1'b1, 1'b0, 20'hFFFFF};
        tbl[3] = '{1'b1, 22'h000000, 1'b1, 1'b1, 20'h00003};
        tbl[4] = '{1'b1, 22'h155555, 1'b1, 1'b1, 20'h55550};
        tbl[5] = '{1'b1, 22'h0ABCDE, 1'b1, 1'b1, 20'hF3795};
        tbl[6] = '{1'b0, 22'h3FFFFF, 1'b1, 1'b0, 20'hF3795};

        arst_n        = 1'b1;
        slip          = 1'b0;
        bus.din_valid = 1'b0;
        bus.din       = '0;
        #1;
        arst_n = 1'b0;
        #1;
        chk("reset_dout", {12'd0, bus.dout}, 32'd0);
        chk("reset_dout_valid", {31'd0, bus.dout_valid}, 32'd0);
        chk("reset_din_ready", {31'd0, bus.din_ready}, 32'd1);

        // Directed table
        do_reset();
        for (int k = 0; k < 7; k++) begin
            bus.din_valid = tbl[k].v;
            bus.din       = tbl[k].d;
            #1;
            rdy_s = bus.din_ready;
            @(posedge clk);
            #1;
            chk($sformatf("tbl%0d_ready", k), {31'd0, rdy_s}, {31'd0, tbl[k].rdy});
            chk($sformatf("tbl%0d_dv", k), {31'd0, bus.dout_valid}, {31'd0, tbl[k].dv});
            chk($sformatf("tbl%0d_dout", k), {12'd0, bus.dout}, {12'd0, tbl[k].dout});
            if (k == 0) chk("count_after_single", {26'd0, dut.count}, 32'd2);
        end

        // Continuous counter stream; the held word while not ready checks backpressure
        do_reset();
        word = '0;
        for (int i = 0; i < 1100; i++) begin
            chk("ready_period", {31'd0, bus.din_ready}, {31'd0, (i % 11) != 10});
            run_cycle(1'b1, word, 1'b0, acc);
            chk("dv_const", {31'd0, bus.dout_valid}, 32'd1);
            if (acc) word = word + 22'd1;
        end
        chk("accepts_in_1100", {10'd0, word}, 32'd1000);

        // Gappy input
        do_reset();
        pending = 1'b0;
        word    = '0;
        for (int i = 0; i < 2000; i++) begin
            v = 1'(($urandom & 32'h1) != 0) | pending;
            if (!pending) word = 22'($urandom);
            run_cycle(v, word, 1'b0, acc);
            pending = v && !acc;
        end

        // Reset mid-stream at count 14
        do_reset();
        for (int i = 0; i < 7; i++) run_cycle(1'b1, 22'h100 + 22'(i), 1'b0, acc);
        chk("count_pre_reset", {26'd0, dut.count}, 32'd14);
        #2;
        arst_n = 1'b0;
        #1;
        chk("midreset_dv", {31'd0, bus.dout_valid}, 32'd0);
        chk("midreset_dout", {12'd0, bus.dout}, 32'd0);
        chk("midreset_count", {26'd0, dut.count}, 32'd0);
        chk("midreset_ready", {31'd0, bus.din_ready}, 32'd1);
        bus.din_valid = 1'b1;
        bus.din       = 22'h3FFFFF;
        @(posedge clk);
        #1;
        chk("inreset_no_xfer_dv", {31'd0, bus.dout_valid}, 32'd0);
        chk("inreset_no_xfer_cnt", {26'd0, dut.count}, 32'd0);
        arst_n    = 1'b1;
        q.delete();
        last_dout = '0;
        run_cycle(1'b1, 22'h2A5A5A, 1'b0, acc);
        chk("post_reset_first", {12'd0, bus.dout}, 32'h000A5A5A);
        for (int i = 0; i < 20; i++) run_cycle(1'b1, 22'h1000 + 22'(i), 1'b0, acc);

`ifdef GB_SLIP_EN
        // Slip at count 0 (no effect) and once mid-stream
        do_reset();
        word = '0;
        for (int i = 0; i < 80; i++) begin
            run_cycle(1'b1, word, (i == 0) || (i == 25), acc);
            if (acc) word = word + 22'd1;
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
